cab_led_seq: RTL and testbench
==============================

CAB_LED_SEQ -- requirements
Module: cab_led_seq

Interface
REQ-001 Parameter SETUP_CYC, default 4, the number of cycles LED_DATA is stable before the latch pulse (legal range 1..255).
REQ-002 Parameter PULSE_CYC, default 8, the latch pulse width in cycles (legal range 1..255).
REQ-003 Parameter HOLD_CYC, default 4, the number of cycles LED_DATA is held after the latch pulse (legal range 1..255).
REQ-004 CLK_24M  input  1  the single clock; all state changes on its rising edge.
REQ-005 nRESET  input  1  reset, asynchronous and active-low.
REQ-006 WR  input  1  write strobe; sampled on each rising edge.
REQ-007 WR_CH  input  2  target channel: 0=EL, 1=LED1, 2=LED2, 3=ignored.
REQ-008 DIN  input  8  write data.
REQ-009 LED_DATA  output  8  shared data bus to the cab latches.
REQ-010 LED_LATCH  output  3  one-hot active-high latch strobes; bit n = channel n.
REQ-011 BUSY  output  1  high whenever the state is not IDLE.
REQ-012 PEND  output  3  per-channel pending flags.

Function
REQ-013 The block SHALL keep one 8-bit value register and one pending flag per channel.
REQ-014 WR=1 with WR_CH<3 SHALL store DIN into that channel's value register and set its pending flag on the same edge; WR_CH=3 SHALL have no effect.
REQ-015 A write to an already-pending channel SHALL overwrite its value; only the latest value SHALL be sequenced (no queue).
REQ-016 The state machine SHALL have four states: IDLE, SETUP, STROBE and HOLD.
REQ-017 In IDLE with any pending flag set, the next edge SHALL grant one channel by round-robin, searching from pointer RR in order RR, RR+1, RR+2 (mod 3).
REQ-018 On the grant edge the block SHALL: load LED_DATA from the granted value register, clear that channel's pending flag, latch the channel index, set RR=(index+1) mod 3, and enter SETUP.
REQ-019 If a write to the granted channel occurs on the grant edge, the pending flag SHALL remain set and the new value SHALL be stored; LED_DATA SHALL take the pre-write value.
REQ-020 An 8-bit down-counter SHALL time each state: SETUP lasts SETUP_CYC cycles, STROBE lasts PULSE_CYC cycles and HOLD lasts HOLD_CYC cycles, then the state returns to IDLE.
REQ-021 LED_LATCH SHALL be registered and SHALL equal the one-hot code of the granted channel only while in STROBE; it SHALL be 0 in all other states.
REQ-022 LED_DATA SHALL be constant from the grant edge through the end of HOLD, and SHALL retain its last value in IDLE.
REQ-023 Writes during SETUP, STROBE or HOLD SHALL only update the value registers and pending flags; they SHALL NOT alter the transfer in progress.
REQ-024 IDLE SHALL last exactly one cycle between back-to-back transfers when any flag is pending at HOLD exit.
REQ-025 Latency SHALL be as follows for a write at edge E to an idle block with no other pending flags: grant at E+1; LED_LATCH asserted for edges E+1+SETUP_CYC through E+SETUP_CYC+PULSE_CYC; IDLE re-entered at E+1+SETUP_CYC+PULSE_CYC+HOLD_CYC.

Reset
REQ-026 While nRESET=0, the block SHALL force: state=IDLE, LED_DATA=0x00, LED_LATCH=3'b000, BUSY=0, PEND=3'b000, all value registers=0x00, RR=0, counter=0.
REQ-027 Reset asserted mid-transfer SHALL drop LED_LATCH to 0 immediately (asynchronously) and SHALL discard all pending work.
REQ-028 After nRESET deasserts, the block SHALL accept writes from the first rising edge onward.

Verification
REQ-029 Directed scenario: write CH1=0x5A at edge 0 (defaults) -> LED_DATA=0x5A from edge 1; LED_LATCH=3'b010 for edges 5..12; BUSY=0 from edge 17.
REQ-030 Directed scenario: writes CH0=0x03, CH2=0x81, CH1=0x22 on edges 0, 1, 2 -> strobes occur in order 001 (data 0x03), 010 (0x22), 100 (0x81), each separated by one IDLE cycle.
REQ-031 Directed scenario: write CH2=0x11 then CH2=0x99 before its grant -> exactly one transfer occurs, with data 0x99.
REQ-032 Directed scenario: write CH1=0x44 during the CH1 STROBE of 0x5A -> 0x5A completes unchanged, then a second CH1 transfer of 0x44 follows.
REQ-033 Directed scenario: pulse nRESET low during STROBE -> LED_LATCH=0, LED_DATA=0x00 and PEND=0 with no clock edge required.
REQ-034 Directed scenario: run with SETUP_CYC=1, PULSE_CYC=1, HOLD_CYC=1 and WR_CH=3 writes interleaved -> 1-cycle phases; WR_CH=3 writes produce no PEND change.

Source files
------------

// File: rtl/cab_led_seq.sv
// Cab LED latch sequencer: three buffered 8-bit channels share one data bus and
// are transferred one at a time as setup / latch-strobe / hold phases.
module cab_led_seq #(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 8,
    parameter int HOLD_CYC  = 4
) (
    input  logic       CLK_24M,
    input  logic       nRESET,
    input  logic       WR,
    input  logic [1:0] WR_CH,
    input  logic [7:0] DIN,
    output logic [7:0] LED_DATA,
    output logic [2:0] LED_LATCH,
    output logic       BUSY,
    output logic [2:0] PEND
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] chan_q, chan_d;
    logic [1:0] rr_q, rr_d;
    logic [2:0] pend_q, pend_d;
    logic [7:0] val_q [3];
    logic [7:0] val_d [3];
    logic [7:0] data_q, data_d;
    logic [2:0] latch_q, latch_d;

    logic       grant_vld;
    logic [1:0] grant_ch;
    logic [1:0] idx;
    logic [7:0] grant_val;

    function automatic logic [1:0] wrap3(input logic [2:0] x);
        return (x >= 3'd3) ? 2'(x - 3'd3) : x[1:0];
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = 2'd0;
        idx       = 2'd0;
        grant_val = 8'h00;
        // Scan from lowest to highest priority so the offset nearest RR wins.
        for (int i = 2; i >= 0; i--) begin
            idx = wrap3({1'b0, rr_q} + 3'(i));
            if (pend_q[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = idx;
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (grant_ch == 2'(c)) begin
                grant_val = val_q[c];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        rr_d    = rr_q;
        pend_d  = pend_q;
        val_d   = val_q;
        data_d  = data_q;
        latch_d = latch_q;

        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = SETUP;
                    data_d  = grant_val;
                    pend_d  = pend_q & ~(3'b001 << grant_ch);
                    chan_d  = grant_ch;
                    rr_d    = wrap3({1'b0, grant_ch} + 3'd1);
                    cnt_d   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = STROBE;
                    cnt_d   = PULSE_LD;
                    latch_d = 3'b001 << chan_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    latch_d = 3'b000;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied after the grant so a same-edge write keeps the channel pending.
        for (int c = 0; c < 3; c++) begin
            if (WR && (WR_CH == 2'(c))) begin
                val_d[c]  = DIN;
                pend_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            chan_q  <= 2'd0;
            rr_q    <= 2'd0;
            pend_q  <= 3'b000;
            val_q   <= '{default: 8'h00};
            data_q  <= 8'h00;
            latch_q <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            val_q   <= val_d;
            data_q  <= data_d;
            latch_q <= latch_d;
        end
    end

    assign LED_DATA  = data_q;
    assign LED_LATCH = latch_q;
    assign BUSY      = (state_q != IDLE);
    assign PEND      = pend_q;

endmodule

// File: tb/tb_cab_led_seq.sv
// Bench for cab_led_seq: default-timing and 1/1/1-timing instances share stimulus
// and are checked every cycle against a transaction-level model.
module tb_cab_led_seq;

    logic       clk = 1'b0;
    logic       nrst;
    logic       wr;
    logic [1:0] wr_ch;
    logic [7:0] din;

    logic [7:0] led_data  [2];
    logic [2:0] led_latch [2];
    logic       busy      [2];
    logic [2:0] pend      [2];

    always #5 clk = ~clk;

    cab_led_seq #(.SETUP_CYC(4), .PULSE_CYC(8), .HOLD_CYC(4)) dut0 (
        .CLK_24M(clk), .nRESET(nrst), .WR(wr), .WR_CH(wr_ch), .DIN(din),
        .LED_DATA(led_data[0]), .LED_LATCH(led_latch[0]), .BUSY(busy[0]), .PEND(pend[0])
    );

    cab_led_seq #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut1 (
        .CLK_24M(clk), .nRESET(nrst), .WR(wr), .WR_CH(wr_ch), .DIN(din),
        .LED_DATA(led_data[1]), .LED_LATCH(led_latch[1]), .BUSY(busy[1]), .PEND(pend[1])
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int setup_c [2] = '{4, 1};
    int pulse_c [2] = '{8, 1};
    int hold_c  [2] = '{4, 1};

    // Transaction model: a transfer is just (grant edge, channel, data); outputs
    // follow from the edges elapsed since the grant.
    int         edge_n = 0;
    bit         m_busy [2];
    int         m_g    [2];
    int         m_ch   [2];
    int         m_data [2];
    int         m_val  [2][3];
    logic [2:0] m_pend [2];
    int         m_rr   [2];

    int ev[$];
    logic [2:0] prev_latch = 3'b000;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelEdge(input int k);
        int c;
        if (!nrst) begin
            m_busy[k] = 1'b0;
            m_g[k]    = 0;
            m_ch[k]   = 0;
            m_data[k] = 0;
            m_pend[k] = 3'b000;
            m_rr[k]   = 0;
            for (int j = 0; j < 3; j++) m_val[k][j] = 0;
        end else begin
            if (m_busy[k] && (edge_n - m_g[k] == setup_c[k] + pulse_c[k] + hold_c[k])) begin
                m_busy[k] = 1'b0;
            end else if (!m_busy[k] && (m_pend[k] != 3'b000)) begin
                for (int j = 2; j >= 0; j--) begin
                    c = (m_rr[k] + j) % 3;
                    if (m_pend[k][c]) m_ch[k] = c;
                end
                m_busy[k] = 1'b1;
                m_g[k]    = edge_n;
                m_data[k] = m_val[k][m_ch[k]];
                m_pend[k][m_ch[k]] = 1'b0;
                m_rr[k]   = (m_ch[k] + 1) % 3;
            end
            if (wr && wr_ch != 2'd3) begin
                m_val[k][wr_ch]  = int'(din);
                m_pend[k][wr_ch] = 1'b1;
            end
        end
    endtask

    function automatic int expLatch(input int k);
        int t;
        if (!m_busy[k]) return 0;
        t = edge_n - m_g[k];
        if (t >= setup_c[k] && t < setup_c[k] + pulse_c[k]) return 1 << m_ch[k];
        return 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            for (int k = 0; k < 2; k++) modelEdge(k);
            #1;
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("dut%0d LED_DATA e%0d", k, edge_n), int'(led_data[k]), m_data[k]);
                checkOutput($sformatf("dut%0d LED_LATCH e%0d", k, edge_n), int'(led_latch[k]), expLatch(k));
                checkOutput($sformatf("dut%0d BUSY e%0d", k, edge_n), int'(busy[k]), int'(m_busy[k]));
                checkOutput($sformatf("dut%0d PEND e%0d", k, edge_n), int'(pend[k]), int'(m_pend[k]));
            end
        end
    end

    task automatic applyStimulus(input bit w, input int ch, input int d);
        @(negedge clk);
        wr    = w;
        wr_ch = 2'(ch);
        din   = 8'(d);
        @(posedge clk);
        #1;
        if (led_latch[0] != 3'b000 && prev_latch == 3'b000)
            ev.push_back(int'({led_latch[0], led_data[0]}));
        prev_latch = led_latch[0];
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        nrst = 1'b0;
        wr   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        prev_latch = 3'b000;
    endtask

    initial begin
        nrst  = 1'b0;
        wr    = 1'b0;
        wr_ch = 2'd0;
        din   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // Single CH1 write at edge 0 on both timings.
        applyStimulus(1'b1, 1, 'h5A);
        for (int e = 1; e <= 20; e++) begin
            applyStimulus(1'b0, 0, 0);
            if (e == 1)  checkOutput("d0 data e1", int'(led_data[0]), 'h5A);
            if (e == 4)  checkOutput("d0 latch e4", int'(led_latch[0]), 0);
            if (e == 5)  checkOutput("d0 latch e5", int'(led_latch[0]), 2);
            if (e == 12) checkOutput("d0 latch e12", int'(led_latch[0]), 2);
            if (e == 13) checkOutput("d0 latch e13", int'(led_latch[0]), 0);
            if (e == 16) checkOutput("d0 busy e16", int'(busy[0]), 1);
            if (e == 17) checkOutput("d0 busy e17", int'(busy[0]), 0);
            if (e == 1)  checkOutput("d1 latch e1", int'(led_latch[1]), 0);
            if (e == 2)  checkOutput("d1 latch e2", int'(led_latch[1]), 2);
            if (e == 3)  checkOutput("d1 latch e3", int'(led_latch[1]), 0);
            if (e == 3)  checkOutput("d1 busy e3", int'(busy[1]), 1);
            if (e == 4)  checkOutput("d1 busy e4", int'(busy[1]), 0);
        end

        // Channel 3 writes are ignored.
        applyStimulus(1'b1, 3, 'hFF);
        checkOutput("ch3 pend d0", int'(pend[0]), 0);
        checkOutput("ch3 busy d0", int'(busy[0]), 0);
        applyStimulus(1'b1, 0, 'h33);
        applyStimulus(1'b1, 3, 'hEE);
        checkOutput("ch3 pend d1", int'(pend[1]), 0);
        checkOutput("ch3 busy d1", int'(busy[1]), 1);
        idleCycles(25);

        // Round-robin order of three queued channels.
        ev.delete();
        applyStimulus(1'b1, 0, 'h03);
        applyStimulus(1'b1, 2, 'h81);
        applyStimulus(1'b1, 1, 'h22);
        idleCycles(70);
        checkOutput("rr count", ev.size(), 3);
        if (ev.size() == 3) begin
            checkOutput("rr first", ev[0], 'h103);
            checkOutput("rr second", ev[1], 'h222);
            checkOutput("rr third", ev[2], 'h481);
        end

        // Overwrite of a pending channel before its grant.
        ev.delete();
        applyStimulus(1'b1, 0, 'h10);
        applyStimulus(1'b0, 0, 0);
        applyStimulus(1'b1, 2, 'h11);
        applyStimulus(1'b1, 2, 'h99);
        idleCycles(50);
        checkOutput("ovw count", ev.size(), 2);
        if (ev.size() == 2) begin
            checkOutput("ovw first", ev[0], 'h110);
            checkOutput("ovw second", ev[1], 'h499);
        end

        // Write to the strobing channel queues a second transfer.
        ev.delete();
        applyStimulus(1'b1, 1, 'h5A);
        idleCycles(6);
        checkOutput("strobe before wr", int'(led_latch[0]), 2);
        applyStimulus(1'b1, 1, 'h44);
        checkOutput("data kept", int'(led_data[0]), 'h5A);
        idleCycles(50);
        checkOutput("rewr count", ev.size(), 2);
        if (ev.size() == 2) begin
            checkOutput("rewr first", ev[0], 'h25A);
            checkOutput("rewr second", ev[1], 'h244);
        end

        // Asynchronous reset in the middle of a strobe.
        applyStimulus(1'b1, 0, 'hC3);
        idleCycles(5);
        applyStimulus(1'b1, 1, 'h77);
        checkOutput("pre-rst latch", int'(led_latch[0]), 1);
        checkOutput("pre-rst pend", int'(pend[0]), 2);
        @(negedge clk);
        wr = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("async rst latch", int'(led_latch[0]), 0);
        checkOutput("async rst data", int'(led_data[0]), 0);
        checkOutput("async rst pend", int'(pend[0]), 0);
        checkOutput("async rst busy", int'(busy[0]), 0);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        prev_latch = 3'b000;

        // Randomized traffic alternating sparse and dense phases.
        for (int i = 0; i < 3000; i++) begin
            int dens;
            if (i == 1500) doReset();
            dens = ((i / 500) % 2 == 1) ? 1 : 7;
            applyStimulus(($urandom_range(0, dens) == 0), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 255)));
        end
        idleCycles(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
